// File: rtl/nec_ir_decoder.sv
// NEC infrared frame decoder: measures pulse widths on the synchronised pin,
// assembles the 32-bit frame, checks complements and reports command / repeats.
module nec_ir_decoder #(
    parameter int unsigned LEAD_L_MIN = 400_000,
    parameter int unsigned LEAD_L_MAX = 500_000,
    parameter int unsigned LEAD_H_MIN = 200_000,
    parameter int unsigned LEAD_H_MAX = 250_000,
    parameter int unsigned REP_H_MIN  = 100_000,
    parameter int unsigned REP_H_MAX  = 137_500,
    parameter int unsigned BIT_L_MIN  = 20_000,
    parameter int unsigned BIT_L_MAX  = 35_000,
    parameter int unsigned ZERO_H_MIN = 20_000,
    parameter int unsigned ZERO_H_MAX = 35_000,
    parameter int unsigned ONE_H_MIN  = 75_000,
    parameter int unsigned ONE_H_MAX  = 95_000,
    parameter int unsigned TIMEOUT    = 600_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        inf_in,
    output logic [19:0] data,
    output logic [7:0]  addr,
    output logic        frame_vld,
    output logic        repeat_en
);

    localparam logic [19:0] T_OUT = 20'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_L,
        LEAD_H,
        BIT_L,
        BIT_H,
        CHECK
    } state_t;

    state_t      state;
    logic        s1, s2, s3;
    logic        fall, rise;
    logic [19:0] cnt;
    logic [4:0]  bit_idx;
    logic [31:0] shift_reg;
    logic        have_frame;

    function automatic logic in_win(input logic [19:0] v, input int unsigned lo, input int unsigned hi);
        return (v >= 20'(lo)) && (v <= 20'(hi));
    endfunction

    // The pin is asynchronous; the first two flops resolve metastability.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= inf_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall = s3 & ~s2;
    assign rise = ~s3 & s2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= 20'd0;
        end else if (fall || rise) begin
            cnt <= 20'd0;
        end else if (cnt != T_OUT) begin
            cnt <= cnt + 20'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            bit_idx    <= 5'd0;
            shift_reg  <= 32'd0;
            have_frame <= 1'b0;
            data       <= 20'd0;
            addr       <= 8'd0;
            frame_vld  <= 1'b0;
            repeat_en  <= 1'b0;
        end else begin
            frame_vld <= 1'b0;
            repeat_en <= 1'b0;
            if (state != IDLE && cnt == T_OUT) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (fall) begin
                            state <= LEAD_L;
                        end
                    end
                    LEAD_L: begin
                        if (rise) begin
                            state <= in_win(cnt, LEAD_L_MIN, LEAD_L_MAX) ? LEAD_H : IDLE;
                        end
                    end
                    LEAD_H: begin
                        if (fall) begin
                            if (in_win(cnt, LEAD_H_MIN, LEAD_H_MAX)) begin
                                state     <= BIT_L;
                                bit_idx   <= 5'd0;
                                shift_reg <= 32'd0;
                            end else begin
                                repeat_en <= in_win(cnt, REP_H_MIN, REP_H_MAX) && have_frame;
                                state     <= IDLE;
                            end
                        end
                    end
                    BIT_L: begin
                        if (rise) begin
                            state <= in_win(cnt, BIT_L_MIN, BIT_L_MAX) ? BIT_H : IDLE;
                        end
                    end
                    BIT_H: begin
                        // LSB arrives first, so shifting right leaves it in bit 0 after 32 bits.
                        if (fall) begin
                            if (in_win(cnt, ZERO_H_MIN, ZERO_H_MAX) || in_win(cnt, ONE_H_MIN, ONE_H_MAX)) begin
                                shift_reg <= {in_win(cnt, ONE_H_MIN, ONE_H_MAX), shift_reg[31:1]};
                                if (bit_idx == 5'd31) begin
                                    state <= CHECK;
                                end else begin
                                    bit_idx <= bit_idx + 5'd1;
                                    state   <= BIT_L;
                                end
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    CHECK: begin
                        if (shift_reg[15:8] == ~shift_reg[7:0] && shift_reg[31:24] == ~shift_reg[23:16]) begin
                            addr       <= shift_reg[7:0];
                            data       <= {12'd0, shift_reg[23:16]};
                            frame_vld  <= 1'b1;
                            have_frame <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/nec_ir_decoder.md
# nec_ir_decoder

- Decodes the demodulated NEC infrared stream from the IR receiver module.
- Recovers the 8-bit address and 8-bit command, and checks both against their transmitted complements.
- Presents the command on a 20-bit `data` bus to the seven-segment display driver, and issues a repeat pulse to the LED controller.
- Sits directly upstream of the display and LED stages, between the board pin `inf_in` and those consumers.

## Interface
Parameters (all counts in `sys_clk` cycles, 50 MHz):
- `LEAD_L_MIN` = 400_000, `LEAD_L_MAX` = 500_000: accepted leader-low window (8–10 ms).
- `LEAD_H_MIN` = 200_000, `LEAD_H_MAX` = 250_000: accepted leader-high window for a data frame (4–5 ms).
- `REP_H_MIN` = 100_000, `REP_H_MAX` = 137_500: accepted leader-high window for a repeat frame (2–2.75 ms).
- `BIT_L_MIN` = 20_000, `BIT_L_MAX` = 35_000: accepted bit-low burst window (400–700 µs).
- `ZERO_H_MIN` = 20_000, `ZERO_H_MAX` = 35_000: high time that decodes as logic 0.
- `ONE_H_MIN` = 75_000, `ONE_H_MAX` = 95_000: high time that decodes as logic 1 (1.5–1.9 ms).
- `TIMEOUT` = 600_000: 12 ms without an edge aborts any in-progress frame.

Ports:
- `sys_clk`  in  1  system clock, 50 MHz; the only clock.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `inf_in`  in  1  demodulated IR input; asynchronous to `sys_clk`; idle high, bursts low.
- `data`  out  20  {12'd0, command}; held between frames.
- `addr`  out  8  address byte of the last valid frame.
- `frame_vld`  out  1  one-cycle pulse when a complement-checked frame is accepted.
- `repeat_en`  out  1  one-cycle pulse on an accepted repeat frame.

## Operation
Input conditioning:
- `inf_in` passes through a 3-flop chain, `s1`→`s2`→`s3`, all reset to 1.
- `fall` = `s3 & ~s2`; `rise` = `~s3 & s2`.

Duration counter:
- 20-bit `cnt` clears on `fall` or `rise`; otherwise it increments.
- It saturates at `TIMEOUT`.
- Window checks compare `cnt` at the edge, MIN ≤ cnt ≤ MAX inclusive.

State machine:
- IDLE:
  - `fall` → LEAD_L.
  - `rise` is ignored (this is the end of the stop burst).
- LEAD_L, on `rise`:
  - `cnt` in the leader-low window → LEAD_H.
  - Otherwise → IDLE.
- LEAD_H, on `fall`:
  - `cnt` in the leader-high window → BIT_L, with `bit_idx` = 0 and the shift register cleared.
  - `cnt` in the repeat window → pulse `repeat_en` only if `have_frame` = 1, then → IDLE.
  - Otherwise → IDLE.
- BIT_L, on `rise`:
  - `cnt` in the bit-low window → BIT_H.
  - Otherwise → IDLE.
- BIT_H, on `fall`:
  - `cnt` in the zero window → shift in 0.
  - `cnt` in the one window → shift in 1.
  - Otherwise → IDLE with no update.
  - Bits arrive LSB first, into a 32-bit register filled from bit 31 downward.
  - If `bit_idx` < 31: increment `bit_idx` and → BIT_L.
  - If `bit_idx` = 31: → CHECK.
- CHECK (one cycle), with `f` the assembled 32-bit frame:
  - Valid when `f[15:8]` == ~`f[7:0]` and `f[31:24]` == ~`f[23:16]`.
  - If valid: `addr` ← `f[7:0]`, `data` ← {12'd0, `f[23:16]`}, `frame_vld` pulses, `have_frame` ← 1.
  - If invalid: outputs hold.
  - Either way → IDLE.
- Timeout: in any non-IDLE state, `cnt` == `TIMEOUT` → IDLE. Outputs hold and no pulse is issued.
- `have_frame` is cleared only by reset. A repeat frame never alters `data` or `addr`.

Boundary conditions:
- A `fall` in IDLE during the 560 µs stop burst is impossible; the stop-burst fall is consumed as the 32nd bit terminator.
- A new leader arriving while a frame is in progress is treated as a malformed bit, so the frame aborts to IDLE. That leader is lost; the next frame decodes normally.
- Reset mid-frame returns to the reset state immediately, with all partial data discarded.

## Timing
- Reset values:
  - `data` = 20'h00000, `addr` = 8'h00.
  - `frame_vld` = 0, `repeat_en` = 0.
  - State IDLE, `have_frame` = 0, `cnt` = 0, sync flops = 1.
- Edge detection latency: a pin transition sampled by `s1` at clock edge k is seen as `fall`/`rise` during cycle k+2.
- `repeat_en` rises at edge k+3 after the pin falling edge ending the repeat space.
- `frame_vld` and the new `data`/`addr` values appear at edge k+4 after the pin falling edge that starts the stop burst (one cycle later than `repeat_en`, because of CHECK).
- `data` and `addr` change on the same edge `frame_vld` rises.
- Each pulse is high for exactly one cycle.

## Test plan
- Valid frame, addr 0x00, cmd 0x45 (bytes 00 FF 45 BA, nominal NEC timing) → exactly one `frame_vld` pulse; `data` = 20'h00045; `addr` = 8'h00; `repeat_en` stays 0.
- Same frame, then a repeat frame (9 ms low, 2.25 ms high, 560 µs low) 40 ms after the end of the first frame → one `repeat_en` pulse 3 cycles after the space-ending fall; `data` stays 20'h00045; no `frame_vld`.
- Repeat frame immediately after reset → no `repeat_en`; `data` = 0.
- Frame with bytes 00 FF 45 BB (bad command complement) after a valid cmd 0x16 frame → no `frame_vld`; `data` stays 20'h00016.
- Leader low of 6 ms followed by the rest of a valid frame → rejected, no pulse. A subsequent clean frame with cmd 0x0C → `data` = 20'h0000C.
- Line released high after 16 bits → FSM in IDLE 12 ms after the last edge, no outputs. Assert `sys_rst_n` low mid-frame → all outputs 0 immediately. The next valid frame after release decodes correctly.
